// File: rtl/spi_cmd_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_cmd_arbiter_if: requester-side and SPI-master-side signals   |
// | of spi_cmd_arbiter. Rev 1.0                                      |
// +------------------------------------------------------------------+
interface spi_cmd_arbiter_if #(
  parameter int NUM_REQ         = 3,
  parameter int MOSI_DATA_WIDTH = 24,
  parameter int MISO_DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]                 i_req;
  logic [NUM_REQ-1:0]                 i_rd;
  logic [NUM_REQ*MOSI_DATA_WIDTH-1:0] i_data;
  logic [NUM_REQ-1:0]                 i_lock;
  logic [NUM_REQ-1:0]                 o_gnt;
  logic [NUM_REQ-1:0]                 o_ack;
  logic                               o_err;
  logic [MISO_DATA_WIDTH-1:0]         o_rd_data;
  logic                               o_spi_wr_cmd;
  logic                               o_spi_rd_cmd;
  logic [MOSI_DATA_WIDTH-1:0]         o_spi_wr_data;
  logic [MISO_DATA_WIDTH-1:0]         i_spi_rd_data;
  logic                               i_spi_busy;

  // Arbiter view.
  modport slave (
    input  i_req, i_rd, i_data, i_lock, i_spi_rd_data, i_spi_busy,
    output o_gnt, o_ack, o_err, o_rd_data, o_spi_wr_cmd, o_spi_rd_cmd, o_spi_wr_data
  );

  // Requesters plus SPI master view.
  modport master (
    output i_req, i_rd, i_data, i_lock, i_spi_rd_data, i_spi_busy,
    input  o_gnt, o_ack, o_err, o_rd_data, o_spi_wr_cmd, o_spi_rd_cmd, o_spi_wr_data
  );
endinterface
`default_nettype wire

// File: rtl/spi_cmd_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_cmd_arbiter: round-robin sharing of one SPI master among     |
// | NUM_REQ sources, optional lock. SPI_ARB_FIXED_PRIO_EN selects    |
// | lowest-index-wins arbitration. Rev 1.0                           |
// +------------------------------------------------------------------+
module spi_cmd_arbiter #(
  parameter int NUM_REQ         = 3,
  parameter int MOSI_DATA_WIDTH = 24,
  parameter int MISO_DATA_WIDTH = 8,
  parameter int START_TIMEOUT   = 255
) (
  input wire logic          clk,
  input wire logic          rst,
  spi_cmd_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(START_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ISSUE      = 3'd1;
  localparam logic [2:0] S_WAIT_START = 3'd2;
  localparam logic [2:0] S_WAIT_DONE  = 3'd3;
  localparam logic [2:0] S_RESP       = 3'd4;

  logic [2:0]                 r_state, w_next_state;
  logic [IDX_W-1:0]           r_idx, r_lock_idx, w_win_idx;
  logic                       r_rd, r_lock_valid, r_err;
  logic                       w_win, w_lock_hold, w_arb_go, w_timeout;
  logic [MOSI_DATA_WIDTH-1:0] r_frame;
  logic [NUM_REQ-1:0]         r_gnt, w_eligible;
  logic [TMR_W-1:0]           r_timer;
  logic [MISO_DATA_WIDTH-1:0] r_rd_data;

  // The lock survives in IDLE only while its owner still asserts req or lock.
  assign w_lock_hold = r_lock_valid && (bus.i_req[r_lock_idx] || bus.i_lock[r_lock_idx]);
  assign w_arb_go    = (r_state == S_IDLE) && !bus.i_spi_busy && w_win;

  always_comb begin
    w_eligible = bus.i_req;
    if (w_lock_hold) begin
      w_eligible             = '0;
      w_eligible[r_lock_idx] = bus.i_req[r_lock_idx];
    end
  end

`ifdef SPI_ARB_FIXED_PRIO_EN
  always_comb begin
    w_win     = 1'b0;
    w_win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_win     = 1'b1;
        w_win_idx = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] r_rr_ptr;

  // Scan downward so the nearest set request at/after the pointer wins last.
  always_comb begin
    int k;
    k         = 0;
    w_win     = 1'b0;
    w_win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = int'(r_rr_ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (w_eligible[IDX_W'(k)]) begin
        w_win     = 1'b1;
        w_win_idx = IDX_W'(k);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE:       if (w_arb_go) w_next_state = S_ISSUE;
      S_ISSUE:      w_next_state = S_WAIT_START;
      S_WAIT_START: begin
        if (bus.i_spi_busy) begin
          w_next_state = S_WAIT_DONE;
        end else if (r_timer == TMR_W'(START_TIMEOUT)) begin
          w_timeout    = 1'b1;
          w_next_state = S_RESP;
        end
      end
      S_WAIT_DONE:  if (!bus.i_spi_busy) w_next_state = S_RESP;
      S_RESP:       w_next_state = S_IDLE;
      default:      w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= '0;
      r_rd         <= 1'b0;
      r_frame      <= '0;
      r_gnt        <= '0;
      r_lock_valid <= 1'b0;
      r_lock_idx   <= '0;
      r_timer      <= '0;
      r_err        <= 1'b0;
      r_rd_data    <= '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
      r_rr_ptr     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_lock_hold) r_lock_valid <= 1'b0;
          if (w_arb_go) begin
            r_idx   <= w_win_idx;
            r_rd    <= bus.i_rd[w_win_idx];
            r_frame <= bus.i_data[int'(w_win_idx)*MOSI_DATA_WIDTH +: MOSI_DATA_WIDTH];
            r_gnt   <= NUM_REQ'(1) << w_win_idx;
          end else if (!w_lock_hold) begin
            r_gnt <= '0;
          end
        end
        S_ISSUE: r_timer <= '0;
        S_WAIT_START: begin
          if (w_timeout)            r_err   <= 1'b1;
          else if (!bus.i_spi_busy) r_timer <= r_timer + 1'b1;
        end
        S_WAIT_DONE: begin
          if (!bus.i_spi_busy && r_rd) r_rd_data <= bus.i_spi_rd_data;
        end
        S_RESP: begin
          r_err <= 1'b0;
`ifndef SPI_ARB_FIXED_PRIO_EN
          r_rr_ptr <= (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
`endif
          if (bus.i_lock[r_idx]) begin
            r_lock_valid <= 1'b1;
            r_lock_idx   <= r_idx;
          end else begin
            r_lock_valid <= 1'b0;
            r_gnt        <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.o_spi_wr_cmd  = 1'b0;
    bus.o_spi_rd_cmd  = 1'b0;
    bus.o_ack         = '0;
    bus.o_err         = 1'b0;
    bus.o_spi_wr_data = '0;
    if (r_state != S_IDLE) bus.o_spi_wr_data = r_frame;
    case (r_state)
      S_ISSUE: begin
        bus.o_spi_rd_cmd = r_rd;
        bus.o_spi_wr_cmd = !r_rd;
      end
      S_RESP: begin
        bus.o_ack = NUM_REQ'(1) << r_idx;
        bus.o_err = r_err;
      end
      default: ;
    endcase
  end

  assign bus.o_gnt     = r_gnt;
  assign bus.o_rd_data = r_rd_data;
endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_spi_cmd_arbiter: directed vector table plus multi-cycle       |
// | sequences (timeout, reset abort, fairness, lock). Rev 1.0        |
// +------------------------------------------------------------------+
module tb_spi_cmd_arbiter;
  localparam int NR = 3;
  localparam int MW = 24;
  localparam int RW = 8;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_cmd_arbiter_if #(.NUM_REQ(NR), .MOSI_DATA_WIDTH(MW), .MISO_DATA_WIDTH(RW)) bus();

  spi_cmd_arbiter #(
    .NUM_REQ(NR), .MOSI_DATA_WIDTH(MW), .MISO_DATA_WIDTH(RW), .START_TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_len    = 5;
  bit          m_start_en = 1'b1;
  logic [7:0]  m_miso   = 8'h00;
  int          m_cnt    = 0;
  int          n_pulses = 0;

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  rd;
    logic [23:0] d0, d1, d2;
    int          len;
    logic [7:0]  miso;
    int          exp_idx;
    bit          exp_rd;
    logic [23:0] exp_frame;
    logic [7:0]  exp_rd_data;
  } vec_t;

  vec_t vecs[6];

  // SPI master model: busy rises the cycle after a command pulse and stays high m_len cycles.
  initial begin
    bus.i_spi_busy    = 1'b0;
    bus.i_spi_rd_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (bus.o_spi_wr_cmd || bus.o_spi_rd_cmd) n_pulses++;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) bus.i_spi_busy = 1'b0;
      end else if ((bus.o_spi_wr_cmd || bus.o_spi_rd_cmd) && m_start_en) begin
        bus.i_spi_busy    = 1'b1;
        bus.i_spi_rd_data = m_miso;
        m_cnt             = m_len;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_pulse(output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.o_spi_wr_cmd || bus.o_spi_rd_cmd) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_wait: got no pulse, want pulse within 40 cycles");
    end
  endtask

  task automatic wait_ack(input int limit, output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (|bus.o_ack) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_wait: got no ack, want ack within %0d cycles", limit);
    end
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int lat, cyc, n0;
    bit ok;
    bus.i_data = {v.d2, v.d1, v.d0};
    bus.i_rd   = v.rd;
    m_len      = v.len;
    m_miso     = v.miso;
    n0         = n_pulses;
    bus.i_req  = v.req;
    wait_pulse(lat, ok);
    if (ok) begin
      check({tag, "_req_to_cmd"}, 32'(lat <= 2), 32'd1);
      check({tag, "_gnt"}, 32'(bus.o_gnt), 32'(3'b001 << v.exp_idx));
      check({tag, "_rd_cmd"}, 32'(bus.o_spi_rd_cmd), 32'(v.exp_rd));
      check({tag, "_wr_cmd"}, 32'(bus.o_spi_wr_cmd), 32'(!v.exp_rd));
      check({tag, "_wr_data"}, 32'(bus.o_spi_wr_data), 32'(v.exp_frame));
    end
    wait_ack(2 * v.len + 10, cyc, ok);
    if (ok) begin
      check({tag, "_busy_to_ack"}, cyc, v.len + 1);
      check({tag, "_ack"}, 32'(bus.o_ack), 32'(3'b001 << v.exp_idx));
      check({tag, "_err"}, 32'(bus.o_err), 32'd0);
      check({tag, "_rd_data"}, 32'(bus.o_rd_data), 32'(v.exp_rd_data));
    end
    bus.i_req = '0;
    @(negedge clk);
    check({tag, "_ack_one_cycle"}, 32'(bus.o_ack), 32'd0);
    check({tag, "_idle_wr_data"}, 32'(bus.o_spi_wr_data), 32'd0);
    check({tag, "_pulse_count"}, n_pulses - n0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int   lat, cyc, acks;
    bit   ok;
    vec_t v;
    int   exp_order[6];

    bus.i_req  = '0;
    bus.i_rd   = '0;
    bus.i_lock = '0;
    bus.i_data = '0;

    // Fields: req, rd, d0, d1, d2, len, miso, exp_idx, exp_rd, exp_frame, exp_rd_data
    vecs[0] = '{3'b001, 3'b000, 24'h000118, 24'h000000, 24'h000000, 5, 8'h00, 0, 1'b0, 24'h000118, 8'h00};
    vecs[1] = '{3'b010, 3'b010, 24'h000000, 24'h008003, 24'h000000, 3, 8'h53, 1, 1'b1, 24'h008003, 8'h53};
    vecs[2] = '{3'b011, 3'b000, 24'hABCDEF, 24'h111111, 24'h000000, 2, 8'h99, 0, 1'b0, 24'hABCDEF, 8'h53};
`ifdef SPI_ARB_FIXED_PRIO_EN
    vecs[3] = '{3'b111, 3'b100, 24'h0F0F0F, 24'h123456, 24'h800000, 4, 8'h77, 0, 1'b0, 24'h0F0F0F, 8'h53};
    vecs[4] = '{3'b101, 3'b100, 24'h222222, 24'h000000, 24'h80FF00, 6, 8'hA5, 0, 1'b0, 24'h222222, 8'h53};
`else
    vecs[3] = '{3'b111, 3'b100, 24'h0F0F0F, 24'h123456, 24'h800000, 4, 8'h77, 1, 1'b0, 24'h123456, 8'h53};
    vecs[4] = '{3'b101, 3'b100, 24'h222222, 24'h000000, 24'h80FF00, 6, 8'hA5, 2, 1'b1, 24'h80FF00, 8'hA5};
`endif
    vecs[5] = '{3'b110, 3'b010, 24'h000000, 24'h800001, 24'h333333, 2, 8'h3C, 1, 1'b1, 24'h800001, 8'h3C};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(bus.o_gnt), 32'd0);
    check("rst_ack", 32'(bus.o_ack), 32'd0);
    check("rst_err", 32'(bus.o_err), 32'd0);
    check("rst_rd_data", 32'(bus.o_rd_data), 32'd0);
    check("rst_cmds", 32'({bus.o_spi_wr_cmd, bus.o_spi_rd_cmd}), 32'd0);
    check("rst_wr_data", 32'(bus.o_spi_wr_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) apply_vec(vecs[i], $sformatf("v%0d", i));

    // Start timeout: the master never raises busy
    m_start_en = 1'b0;
    bus.i_data = {24'h0C0FFE, 24'h0, 24'h0};
    bus.i_rd   = 3'b000;
    bus.i_req  = 3'b100;
    wait_pulse(lat, ok);
    wait_ack(TO + 10, cyc, ok);
    if (ok) begin
      check("to_latency_in_range", 32'((cyc >= TO) && (cyc <= TO + 4)), 32'd1);
      check("to_ack", 32'(bus.o_ack), 32'b100);
      check("to_err", 32'(bus.o_err), 32'd1);
    end
    bus.i_req  = '0;
    @(negedge clk);
    m_start_en = 1'b1;
    v = '{3'b011, 3'b000, 24'h5A5A5A, 24'h000000, 24'h000000, 3, 8'h00, 0, 1'b0, 24'h5A5A5A, 8'h3C};
    apply_vec(v, "after_to");

    // Reset while waiting for busy to fall
    bus.i_data = {24'h8000AA, 24'h0, 24'h0};
    bus.i_rd   = 3'b100;
    m_len      = 12;
    m_miso     = 8'hEE;
    bus.i_req  = 3'b100;
    wait_pulse(lat, ok);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.i_req = '0;
    check("mid_rst_gnt", 32'(bus.o_gnt), 32'd0);
    check("mid_rst_ack", 32'(bus.o_ack), 32'd0);
    check("mid_rst_wr_data", 32'(bus.o_spi_wr_data), 32'd0);
    check("mid_rst_rd_data", 32'(bus.o_rd_data), 32'd0);
    rst  = 1'b0;
    acks = 0;
    repeat (15) begin
      @(negedge clk);
      if (|bus.o_ack) acks++;
    end
    check("mid_rst_no_ack", acks, 0);
    v = '{3'b011, 3'b000, 24'h0A0A0A, 24'h0B0B0B, 24'h000000, 2, 8'h00, 0, 1'b0, 24'h0A0A0A, 8'h00};
    apply_vec(v, "rr_after_rst");

    // Fairness with all three requesting continuously
    do_reset();
`ifdef SPI_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 0, 1, 2};
`endif
    bus.i_rd   = 3'b000;
    bus.i_data = {24'h000333, 24'h000222, 24'h000111};
    m_len      = 2;
    bus.i_req  = 3'b111;
    for (int i = 0; i < 6; i++) begin
      wait_pulse(lat, ok);
      if (ok) check($sformatf("fair_gnt%0d", i), 32'(bus.o_gnt), 32'(3'b001 << exp_order[i]));
      wait_ack(20, cyc, ok);
      if (i == 5) bus.i_req = '0;
    end
    @(negedge clk);

    // Lock: four frames to source 0 while source 2 waits
    do_reset();
    bus.i_data = {24'h00C200, 24'h0, 24'h00C000};
    bus.i_req  = 3'b101;
    bus.i_lock = 3'b001;
    for (int f = 0; f < 4; f++) begin
      wait_pulse(lat, ok);
      if (ok) check($sformatf("lock_gnt%0d", f), 32'(bus.o_gnt), 32'b001);
      if (f == 3) bus.i_lock = 3'b000;
      wait_ack(20, cyc, ok);
      if (ok) check($sformatf("lock_ack%0d", f), 32'(bus.o_ack), 32'b001);
      if (f == 3) bus.i_req = 3'b100;
      @(negedge clk);
      check($sformatf("lock_idle_gnt%0d", f), 32'(bus.o_gnt), (f < 3) ? 32'b001 : 32'b000);
    end
    wait_pulse(lat, ok);
    if (ok) begin
      check("unlock_gnt", 32'(bus.o_gnt), 32'b100);
      check("unlock_wr_data", 32'(bus.o_spi_wr_data), 32'h00C200);
    end
    wait_ack(20, cyc, ok);
    if (ok) check("unlock_ack", 32'(bus.o_ack), 32'b100);
    bus.i_req = '0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
